// File: rtl/pipelined_ripple_adder.sv
// Pipelined WIDTH-bit add/subtract built from CHUNK-bit ripple slices, one register stage per slice.
// Latency STAGES cycles; a single global advance stalls every stage when the held result is not taken.
module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic              adv;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cry_q, cry_d;
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    // Inputs seen by each stage: stage 0 takes the fresh operands, stage k the registers of k-1.
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cry;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];

    always_comb begin : src_sel
        src_vld    = '0;
        src_cry    = '0;
        src_vld[0] = in_valid;
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_cry[0] = sub | cin;
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_cry[k] = cry_q[k-1];
            src_a[k]   = opa_q[k-1];
            src_b[k]   = opb_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
    end

    always_comb begin : stage_math
        logic [CHUNK:0] add;
        add   = '0;
        adv   = ~vld_q[STAGES-1] | out_ready;
        vld_d = vld_q;
        cry_d = cry_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            opa_d[k] = opa_q[k];
            opb_d[k] = opb_q[k];
            sum_d[k] = sum_q[k];
        end
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                add = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                    + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_cry[k]};
                vld_d[k]                   = src_vld[k];
                opa_d[k]                   = src_a[k];
                opb_d[k]                   = src_b[k];
                sum_d[k]                   = src_sum[k];
                sum_d[k][k*CHUNK +: CHUNK] = add[CHUNK-1:0];
                cry_d[k]                   = add[CHUNK];
            end
            // a^b^sum at the MSB recovers the carry into the MSB.
            ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                  ^ sum_d[STAGES-1][WIDTH-1] ^ cry_d[STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cry_q <= cry_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder (WIDTH=16, CHUNK=4): directed cases, random stream with stall,
// bubble pattern and mid-operation reset, scored against an arithmetic reference model.
module tb_pipelined_ripple_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [17:0] exp_q [$];
    logic        popped, s_in_acc, s_in_rdy, s_out_vld;
    logic [17:0] last_out, s_out;
    int          rx_cnt = 0;

    // Result packed as {sum, cout, ovf}, from integer arithmetic on the operands.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        int ua, ub, sa, sb, ur, r;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (ms) begin
            ur = ua - ub;
            r  = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(mc);
            r  = sa + sb + int'(mc);
            co = (ur > 65535);
        end
        ov = (r > 32767) || (r < -32768);
        return {ur[15:0], co, ov};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes at negedge, score pops, queue pushes, then step past posedge.
    task automatic cycle();
        logic [17:0] e;
        @(negedge clk);
        popped    = 1'b0;
        s_in_rdy  = in_ready;
        s_out_vld = out_valid;
        s_in_acc  = in_valid & in_ready;
        s_out     = {sum, cout, ovf};
        if (out_valid && out_ready) begin
            popped   = 1'b1;
            last_out = s_out;
            rx_cnt++;
            chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result_vs_model", 32'(last_out), 32'(e));
            end
        end
        if (s_in_acc) exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                             input logic tc, input logic ts, input logic [17:0] expv);
        int lat;
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk({tag, "_accept"}, 32'(s_in_acc), 32'd1);
        in_valid = 1'b0;
        lat = 0;
        popped = 1'b0;
        while (!popped && lat < 20) begin
            cycle();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_value"}, 32'(last_out), 32'(expv));
    endtask

    logic [15:0] oa [20];
    logic [15:0] ob [20];
    logic        oc [20];
    logic        os [20];
    logic        inh [24];
    logic        outh [24];

    initial begin
        logic [17:0] held;
        int idx, cyc;
        logic stall;

        // Reset state
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic cases
        single_op("add_basic",   16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 2'b00});
        single_op("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 2'b10});
        single_op("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 2'b01});
        single_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 2'b10});
        single_op("sub_neg",     16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 2'b00});
        single_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 2'b11});

        // Random back-to-back stream with a 3-cycle output stall
        for (int i = 0; i < 20; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 1'($urandom);
            os[i] = 1'($urandom);
        end
        rx_cnt = 0;
        idx = 0;
        cyc = 0;
        held = '0;
        while (rx_cnt < 20 && cyc < 200) begin
            stall = (cyc >= 8) && (cyc <= 10);
            out_ready = ~stall;
            in_valid  = (idx < 20);
            if (idx < 20) begin
                a = oa[idx]; b = ob[idx]; cin = oc[idx]; sub = os[idx];
            end
            cycle();
            if (stall) begin
                chk("stall_in_ready", 32'(s_in_rdy), 32'd0);
                chk("stall_out_valid", 32'(s_out_vld), 32'd1);
                if (cyc == 8) held = s_out;
                else chk("stall_hold", 32'(s_out), 32'(held));
            end else if (s_out_vld && idx < 20) begin
                chk("full_push_pop_in_ready", 32'(s_in_rdy), 32'd1);
            end
            if (s_in_acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(rx_cnt), 32'd20);
        chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Bubbles: alternate in_valid, out_valid must repeat the pattern 4 cycles later
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 16) && (c % 2 == 0);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            cycle();
            inh[c]  = s_in_acc;
            outh[c] = s_out_vld;
            chk("bubble_pattern", 32'(outh[c]), (c >= 4) ? 32'(inh[c-4]) : 32'd0);
        end
        in_valid = 1'b0;
        chk("bubble_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with a full, stalled pipeline
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            a = 16'($urandom) | 16'h0101;
            b = 16'($urandom);
            cin = 1'b0;
            sub = 1'b0;
            cycle();
        end
        chk("prereset_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("post_reset_quiet", 32'(s_out_vld), 32'd0);
        end
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
